// File: rtl/tc_pkg.sv
// -----------------------------------------------------------------------------
// tc_pkg
// Shared definitions for the timer_counter block: FSM state encoding,
// register word offsets, MODE field values and CTRL bit positions.
// -----------------------------------------------------------------------------
package tc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } tc_state_e;

    // Word offsets (bus address [3:2])
    localparam logic [1:0] CTRL_OFS   = 2'd0;
    localparam logic [1:0] PRESET_OFS = 2'd1;
    localparam logic [1:0] COUNT_OFS  = 2'd2;

    // CTRL.MODE values; 10 and 11 act as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // CTRL bit positions
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM_BIT   = 3;
    localparam int CTRL_PS_LSB   = 4;

endpackage

// File: rtl/timer_counter_if.sv
// -----------------------------------------------------------------------------
// timer_counter_if
// Bridge-side register bus of the timer plus its interrupt line.
//   addr : word offset (bus address [3:2])
//   we   : write strobe, sampled at posedge clk
//   din  : write data
//   dout : combinational read data for addr
//   irq  : interrupt request to CP0 HWInt[2]
// master = CPU/bridge side, slave = timer side.
// -----------------------------------------------------------------------------
interface timer_counter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       addr;
    logic             we;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             irq;

    modport master (output addr, output we, output din, input dout, input irq);
    modport slave  (input addr, input we, input din, output dout, output irq);
endinterface

// File: rtl/tc_prescaler.sv
// -----------------------------------------------------------------------------
// tc_prescaler
// Tick generator for the timer count stage. A PRESCALE_W-bit down-counter
// that reloads with presc; tick is high for one cycle every presc+1 cycles
// while run is high. clr reloads the counter so the first tick after a
// clear arrives presc+1 run cycles later.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : reload counter with presc
//   run        : advance the counter
//   presc      : prescale value P
//   tick       : decrement enable for the count stage
// -----------------------------------------------------------------------------
module tc_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] presc,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    assign tick = run && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = presc;
        end else if (run) begin
            cnt_d = (cnt_q == '0) ? presc : cnt_q - PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
// Memory-mapped programmable down-counting timer. The CPU writes PRESET and
// CTRL; the FSM loads COUNT from PRESET, counts down to zero and raises
// irq_flag. One-shot mode keeps the flag until a CPU write to CTRL or PRESET
// and clears EN; auto-reload mode pulses the flag for one cycle and reloads.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : timer_counter_if.slave (addr, we, din, dout, irq)
// Registers: 0=CTRL {PRESCALE, IM, MODE[1:0], EN}, 1=PRESET, 2=COUNT (RO),
// 3=reserved (reads 0).
// Optional feature macro: TC_PRESCALE_EN adds CTRL[4+PRESCALE_W-1:4] = P and
// slows decrements to one every P+1 cycles.
// -----------------------------------------------------------------------------
module timer_counter
    import tc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    timer_counter_if.slave  bus
);

`ifdef TC_PRESCALE_EN
    localparam bit PS_EN = 1'b1;
`else
    localparam bit PS_EN = 1'b0;
`endif

    // Writable CTRL bits; everything else is dropped on write and reads 0.
    localparam logic [WIDTH-1:0] PS_MASK   = ((WIDTH'(1) << PRESCALE_W) - WIDTH'(1)) << CTRL_PS_LSB;
    localparam logic [WIDTH-1:0] CTRL_MASK = WIDTH'(4'hF) | (PS_EN ? PS_MASK : '0);

    tc_state_e        state_q,    state_d;
    logic [WIDTH-1:0] ctrl_q,     ctrl_d;
    logic [WIDTH-1:0] preset_q,   preset_d;
    logic [WIDTH-1:0] count_q,    count_d;
    logic             irq_flag_q, irq_flag_d;

    logic             wr_ctrl;
    logic             wr_preset;
    logic [WIDTH-1:0] ctrl_eff;
    logic             en_q;
    logic             en_eff;
    logic             reload_eff;
    logic             tick;
    logic [WIDTH-1:0] rd_data;

    assign wr_ctrl   = bus.we && (bus.addr == CTRL_OFS);
    assign wr_preset = bus.we && (bus.addr == PRESET_OFS);

    // A CPU write to CTRL overrides anything the FSM does to CTRL this cycle,
    // and the INT decision follows the value being written.
    assign ctrl_eff   = wr_ctrl ? (bus.din & CTRL_MASK) : ctrl_q;
    assign en_q       = ctrl_q[CTRL_EN_BIT];
    assign en_eff     = ctrl_eff[CTRL_EN_BIT];
    assign reload_eff = (ctrl_eff[CTRL_MODE_LSB +: 2] == MODE_RELOAD);

`ifdef TC_PRESCALE_EN
    tc_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   ((state_q == LOAD) || !en_q),
        .run   (state_q == CNT),
        .presc (ctrl_q[CTRL_PS_LSB +: PRESCALE_W]),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_eff;
        preset_d   = wr_preset ? bus.din : preset_q;
        count_d    = count_q;
        irq_flag_d = (wr_ctrl || wr_preset) ? 1'b0 : irq_flag_q;

        unique case (state_q)
            IDLE: begin
                if (en_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // A PRESET written this cycle is picked up at the next LOAD.
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!en_q) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                    end else begin
                        // PRESET=0 lands here too, so it behaves as 1.
                        count_d    = '0;
                        irq_flag_d = 1'b1;
                        state_d    = INT;
                    end
                end
            end
            INT: begin
                if (!en_eff) begin
                    state_d = IDLE;
                end else if (reload_eff) begin
                    irq_flag_d = 1'b0;
                    state_d    = LOAD;
                end else begin
                    state_d = IDLE;
                    if (!wr_ctrl) begin
                        ctrl_d[CTRL_EN_BIT] = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (bus.addr)
            CTRL_OFS:   rd_data = ctrl_q;
            PRESET_OFS: rd_data = preset_q;
            COUNT_OFS:  rd_data = count_q;
            default:    rd_data = '0;
        endcase
    end

    assign bus.dout = rd_data;
    // Both operands are flops, so irq never sees din/we combinationally.
    assign bus.irq  = irq_flag_q & ctrl_q[CTRL_IM_BIT];

endmodule
